// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type and address field helpers for the direct-mapped cache
package cache_pkg;
    typedef enum logic [2:0] {IDLE, LOOKUP, ARB, WRITEBACK, FILL, RESPOND} cache_state_t;

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned index_w);
        return addr & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned index_w);
        return addr >> index_w;
    endfunction
endpackage

// File: rtl/dm_cache_array.sv
// dm_cache_array: tag/data/valid/dirty storage, combinational read, one write port with per-field enables
module dm_cache_array #(
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               rd_dirty,
    input  logic               we_tag,
    input  logic               we_data,
    input  logic               we_valid,
    input  logic               we_dirty,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_valid,
    input  logic               wr_dirty
);
    localparam int LINES = 2 ** INDEX_W;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [LINES-1:0]  valid, dirty;
    assign rd_tag   = tag_mem[idx];
    assign rd_data  = data_mem[idx];
    assign rd_valid = valid[idx];
    assign rd_dirty = dirty[idx];
    // Tag and data arrays are deliberately not reset; only the status bits are.
    always_ff @(posedge clk) begin
        if (we_tag) tag_mem[idx] <= wr_tag;
        if (we_data) data_mem[idx] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (we_valid) valid[idx] <= wr_valid;
            if (we_dirty) dirty[idx] <= wr_dirty;
        end
    end
endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-back write-allocate cache controller with bus arbitration
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 7,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_hit,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    cache_state_t state, state_nx;
    logic [ADDR_W-1:0]  req_addr;
    logic               req_we, hit_q;
    logic [DATA_W-1:0]  req_wdata;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag, line_tag;
    logic [DATA_W-1:0]  line_data;
    logic               line_valid, line_dirty, hit, victim_dirty;
    logic               we_tag, we_data, we_valid, we_dirty;
    assign idx          = INDEX_W'(addr_index(32'(req_addr), INDEX_W));
    assign req_tag      = TAG_W'(addr_tag(32'(req_addr), INDEX_W));
    assign hit          = line_valid && line_tag == req_tag;
    assign victim_dirty = line_valid && line_dirty;

    dm_cache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_array (
        .clk(clk), .rst(rst), .idx(idx),
        .rd_tag(line_tag), .rd_data(line_data), .rd_valid(line_valid), .rd_dirty(line_dirty),
        .we_tag(we_tag), .we_data(we_data), .we_valid(we_valid), .we_dirty(we_dirty),
        .wr_tag(req_tag), .wr_data(state == FILL ? mem_rdata : req_wdata),
        .wr_valid(1'b1), .wr_dirty(req_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            hit_q     <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cpu_req) begin
                req_addr  <= cpu_addr;
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
            end
            if (state == LOOKUP) hit_q <= hit;
            hit_cnt  <= hit_cnt + CNT_W'(state == LOOKUP && hit && hit_cnt != '1);
            miss_cnt <= miss_cnt + CNT_W'(state == LOOKUP && !hit && miss_cnt != '1);
        end
    end

    // Fills only ever serve reads, so wr_dirty = req_we covers fill, allocate and write hit.
    always_comb begin
        state_nx  = state;
        {we_tag, we_data, we_valid, we_dirty} = '0;
        bus_req   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_done  = 1'b0;
        cpu_hit   = 1'b0;
        cpu_rdata = '0;
        case (state)
            IDLE: state_nx = cpu_req ? LOOKUP : IDLE;
            LOOKUP: begin
                if (hit) begin
                    we_data  = req_we;
                    we_dirty = req_we;
                    state_nx = RESPOND;
                end else if (req_we && !victim_dirty) begin
                    {we_tag, we_data, we_valid, we_dirty} = '1;
                    state_nx = RESPOND;
                end else begin
                    state_nx = ARB;
                end
            end
            ARB: begin
                bus_req  = 1'b1;
                state_nx = !bus_gnt ? ARB : victim_dirty ? WRITEBACK : FILL;
            end
            WRITEBACK: begin
                bus_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {line_tag, idx};
                mem_wdata = line_data;
                if (mem_ack) begin
                    {we_tag, we_data, we_valid, we_dirty} = {4{req_we}};
                    state_nx = req_we ? RESPOND : FILL;
                end
            end
            FILL: begin
                bus_req  = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = req_addr;
                if (mem_ack) begin
                    {we_tag, we_data, we_valid, we_dirty} = '1;
                    state_nx = RESPOND;
                end
            end
            RESPOND: begin
                cpu_done  = 1'b1;
                cpu_hit   = hit_q;
                cpu_rdata = req_we ? '0 : line_data;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: scoreboard bench with a flat-memory reference model and randomized traffic
module tb_dm_cache_ctrl;
    localparam int AW = 12, DW = 8, IW = 7, CW = 4, TW = AW - IW;
    logic clk = 1'b0, rst = 1'b1;
    logic cpu_req = 1'b0, cpu_we = 1'b0, bus_gnt, mem_ack;
    logic [AW-1:0] cpu_addr = '0, mem_addr;
    logic [DW-1:0] cpu_wdata = '0, cpu_rdata, mem_wdata, mem_rdata;
    logic cpu_done, cpu_hit, bus_req, mem_rd, mem_wr;
    logic [CW-1:0] hit_cnt, miss_cnt;

    dm_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INDEX_W(IW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_hit(cpu_hit),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        logic          hit, bus, wb;
        logic [AW-1:0] wb_addr;
        logic [DW-1:0] wb_data;
        int            hits, misses, issue_cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, exp_hits = 0, exp_miss = 0;
    bit bus_seen = 0, gnt_hold = 0, mem_hold = 0;
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];
    logic          m_valid [1 << IW];
    logic          m_dirty [1 << IW];
    logic [TW-1:0] m_tag [1 << IW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < (1 << IW); i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = mem[i];
        exp_hits = 0;
        exp_miss = 0;
    endtask

    // The model sees the cache only as "which address each line currently holds";
    // data expectations come from the flat ref_mem view of the latest writes.
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit wait_done);
        exp_t e;
        logic [IW-1:0] idx;
        logic [TW-1:0] t;
        int start;
        idx = a[IW-1:0];
        t = a[AW-1:IW];
        e.we = we;
        e.addr = a;
        e.hit = m_valid[idx] && m_tag[idx] == t;
        e.wb = !e.hit && m_valid[idx] && m_dirty[idx];
        e.bus = !e.hit && (!we || e.wb);
        e.wb_addr = {m_tag[idx], idx};
        e.wb_data = ref_mem[e.wb_addr];
        if (e.hit) exp_hits = exp_hits < 15 ? exp_hits + 1 : 15;
        else exp_miss = exp_miss < 15 ? exp_miss + 1 : 15;
        e.hits = exp_hits;
        e.misses = exp_miss;
        if (we) ref_mem[a] = d;
        e.rdata = ref_mem[a];
        m_dirty[idx] = e.hit ? (m_dirty[idx] | we) : we;
        m_valid[idx] = 1'b1;
        m_tag[idx] = t;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        e.issue_cyc = cyc;
        sb.push_back(e);
        start = done_cnt;
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = AW'($urandom);
        if (wait_done) begin
            for (int i = 0; i < 500 && done_cnt == start; i++) @(posedge clk);
            if (done_cnt == start) begin
                errors++;
                $display("FAIL timeout: no cpu_done for addr %0h", a);
                sb.delete();
            end
        end
    endtask

    // Arbiter: random grant latency, grant held while bus_req stays up.
    initial begin
        bus_gnt = 1'b0;
        forever begin
            @(negedge clk);
            if (!bus_req || gnt_hold) bus_gnt = 1'b0;
            else if (!bus_gnt && $urandom_range(0, 2) == 0) bus_gnt = 1'b1;
        end
    end

    // Memory: one-cycle ack pulse after a random wait.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_hold) continue;
            if (mem_ack) mem_ack = 1'b0;
            else if ((mem_rd || mem_wr) && $urandom_range(0, 2) == 0) begin
                mem_ack = 1'b1;
                if (mem_wr) mem[mem_addr] = mem_wdata;
                else mem_rdata = mem[mem_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_req) bus_seen = 1'b1;
            if (mem_rd && mem_wr) check("strobe_overlap", 32'({mem_rd, mem_wr}), 32'b01);
            if (mem_wr) begin
                if (sb.size() == 0 || !sb[0].wb) check("unexpected_wb", 32'(mem_wr), 32'd0);
                else begin
                    check("wb_addr", 32'(mem_addr), 32'(sb[0].wb_addr));
                    check("wb_data", 32'(mem_wdata), 32'(sb[0].wb_data));
                end
            end
            if (mem_rd) begin
                if (sb.size() == 0 || sb[0].we) check("unexpected_fill", 32'(mem_rd), 32'd0);
                else check("fill_addr", 32'(mem_addr), 32'(sb[0].addr));
            end
            if (cpu_done) begin
                if (sb.size() == 0) check("spurious_done", 32'(cpu_done), 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("cpu_hit", 32'(cpu_hit), 32'(e.hit));
                    if (!e.we) check("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
                    check("bus_used", 32'(bus_seen), 32'(e.bus));
                    if (!e.bus) check("latency", 32'(cyc - e.issue_cyc), 32'd2);
                    check("hit_cnt", 32'(hit_cnt), 32'(e.hits));
                    check("miss_cnt", 32'(miss_cnt), 32'(e.misses));
                end
                bus_seen = 1'b0;
                done_cnt++;
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        mem[12'h005] = 8'h3C;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({cpu_done, cpu_hit, cpu_rdata, bus_req, mem_rd, mem_wr, mem_addr,
                                    mem_wdata, hit_cnt, miss_cnt} != 0), 32'd0);
        rst = 1'b0;
        issue(1'b0, 12'h005, 8'h00, 1'b1);
        issue(1'b0, 12'h005, 8'h00, 1'b1);
        issue(1'b1, 12'h085, 8'hA5, 1'b1);
        issue(1'b0, 12'h085, 8'h00, 1'b1);
        issue(1'b0, 12'h105, 8'h00, 1'b1);
        issue(1'b0, 12'h085, 8'h00, 1'b1);
        // Stall arbitration, then reset while the fill is outstanding.
        gnt_hold = 1'b1;
        mem_hold = 1'b1;
        issue(1'b0, 12'h200, 8'h00, 1'b0);
        repeat (10) begin
            @(negedge clk);
            check("arb_hold", 32'({bus_req, mem_rd, mem_wr}), 32'b100);
        end
        gnt_hold = 1'b0;
        for (int i = 0; i < 100 && !mem_rd; i++) @(negedge clk);
        check("fill_reached", 32'(mem_rd), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midfill_reset", 32'({cpu_done, cpu_hit, cpu_rdata, bus_req, mem_rd, mem_wr, mem_addr,
                                    mem_wdata, hit_cnt, miss_cnt} != 0), 32'd0);
        rst = 1'b0;
        sb.delete();
        bus_seen = 1'b0;
        model_reset();
        mem_hold = 1'b0;
        issue(1'b0, 12'h005, 8'h00, 1'b1);
        // Spurious mem_ack while idle must be ignored.
        mem_hold = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            check("spurious_ack", 32'({cpu_done, bus_req, mem_rd, mem_wr}), 32'd0);
        end
        mem_ack = 1'b0;
        mem_hold = 1'b0;
        issue(1'b0, 12'h005, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) issue(1'b0, {TW'(i), 7'd9}, 8'h00, 1'b1);
        check("miss_sat", 32'(miss_cnt), 32'd15);
        for (int i = 0; i < 300; i++)
            issue($urandom_range(0, 1) == 1, {TW'($urandom_range(0, 3)), IW'($urandom_range(0, 7))},
                  DW'($urandom), 1'b1);
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
